fc_frame_rx: RTL

Receive-side deframer for the 8G FC link. It sits in the `rx_clk` domain after the transceiver byte-swap and `fc_state_rx`. It takes big-endian transmission words and delimits frames on SOF/EOF ordered sets. Complete frames, SOF through EOF, are delivered on an Avalon-ST source with start/end/error sideband. It is the receive counterpart of the transmit path that accepts frames (SOF/EOF words with datak=0) on `avtx`.

---
 rtl/fc_frame_rx.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/fc_frame_rx.sv
// rtl/fc_frame_rx.sv - FC receive deframer: delimits SOF..EOF frames into a show-ahead Avalon-ST FIFO
//
// Ports:
//   clk, reset_n          rx_clk domain clock, synchronous active-low reset
//   data, datak, active   big-endian rx word, K flags, link-Active indication
//   avrx_*                Avalon-ST source: data/valid/ready/startofpacket/endofpacket/error
//   frame_cnt             good frames (saturating)
//   err_cnt               errored/truncated frames (saturating)
//   drop_cnt              frames truncated or refused for FIFO space (saturating)
module fc_frame_rx #(
  parameter int DEPTH     = 16,
  parameter int MAX_WORDS = 537
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] data,
  input  logic [3:0]  datak,
  input  logic        active,
  output logic [31:0] avrx_data,
  output logic        avrx_valid,
  input  logic        avrx_ready,
  output logic        avrx_startofpacket,
  output logic        avrx_endofpacket,
  output logic        avrx_error,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt,
  output logic [15:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] FREE_1  = (AW+1)'(1);
  localparam logic [AW:0] FREE_2  = (AW+1)'(2);
  localparam logic [10:0] MAX_W   = 11'(MAX_WORDS);

  typedef enum logic [1:0] {HUNT, FRAME, DROP} state_t;

  // Input stage
  logic [31:0] data_q;
  logic [3:0]  datak_q;
  logic        active_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q   <= '0;
      datak_q  <= '0;
      active_q <= 1'b0;
    end else begin
      data_q   <= data;
      datak_q  <= datak;
      active_q <= active;
    end
  end

  // Word classification on the registered word
  logic [7:0] b0, b1, b2, b3;
  logic       is_sof, is_eof, is_data;

  assign b0 = data_q[31:24];
  assign b1 = data_q[23:16];
  assign b2 = data_q[15:8];
  assign b3 = data_q[7:0];

  assign is_sof = (datak_q == 4'b1000) && (b0 == 8'hBC) && (b1 == 8'hB5) && (b2 == b3) &&
                  ((b2[4:0] == 5'd22) || (b2[4:0] == 5'd23) || (b2[4:0] == 5'd25));
  assign is_eof = (datak_q == 4'b1000) && (b0 == 8'hBC) &&
                  ((b1 == 8'h95) || (b1 == 8'hB5) || (b1 == 8'h8A) || (b1 == 8'hAA)) &&
                  (b2 == b3) &&
                  ((b2 == 8'h75) || (b2 == 8'h95) || (b2 == 8'hD5) || (b2 == 8'hF5));
  assign is_data = (datak_q == 4'b0000);

  // FIFO storage, entry = {data, sop, eop, err}
  logic [34:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   free;
  logic          push, pop;
  logic [31:0]   wr_data;
  logic          wr_sop, wr_eop, wr_err;
  logic [34:0]   head;

  assign free = DEPTH_W - count;
  assign pop  = (count != '0) && avrx_ready;
  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_data, wr_sop, wr_eop, wr_err};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head fields are forced to zero while empty so the idle/reset bus is clean
  assign avrx_valid         = (count != '0);
  assign avrx_data          = avrx_valid ? head[34:3] : 32'h0;
  assign avrx_startofpacket = avrx_valid & head[2];
  assign avrx_endofpacket   = avrx_valid & head[1];
  assign avrx_error         = avrx_valid & head[0];

  // Deframing FSM
  state_t     state_q, state_d;
  logic [9:0] len_q, len_d;
  logic       take_sof;
  logic       inc_frame, inc_err, inc_drop;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= HUNT;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    push      = 1'b0;
    wr_data   = data_q;
    wr_sop    = 1'b0;
    wr_eop    = 1'b0;
    wr_err    = 1'b0;
    take_sof  = 1'b0;
    inc_frame = 1'b0;
    inc_err   = 1'b0;
    inc_drop  = 1'b0;

    case (state_q)
      HUNT: take_sof = is_sof && active_q;
      FRAME: begin
        if (!active_q) begin
          push = 1'b1; wr_data = 32'h0; wr_eop = 1'b1; wr_err = 1'b1;
          inc_err = 1'b1; state_d = HUNT;
        end else if (is_eof) begin
          push = 1'b1; wr_eop = 1'b1;
          inc_frame = 1'b1; state_d = HUNT;
        end else if (is_data) begin
          push = 1'b1;
          if (({1'b0, len_q} + 11'd1) == MAX_W) begin
            wr_eop = 1'b1; wr_err = 1'b1; inc_err = 1'b1; state_d = DROP;
          end else if (free == FREE_1) begin
            // Last free slot: close the frame here so no eop is ever lost
            wr_eop = 1'b1; wr_err = 1'b1; inc_drop = 1'b1; state_d = DROP;
          end else begin
            len_d = len_q + 10'd1;
          end
        end else if (is_sof) begin
          push = 1'b1; wr_eop = 1'b1; wr_err = 1'b1;
          inc_err = 1'b1; state_d = HUNT;
        end else begin
          push = 1'b1; wr_eop = 1'b1; wr_err = 1'b1;
          inc_err = 1'b1; state_d = DROP;
        end
      end
      DROP: begin
        if (is_eof || !active_q) state_d = HUNT;
        else if (is_sof)         take_sof = 1'b1;
      end
      default: state_d = HUNT;
    endcase

    // Opening a frame needs room for the SOF plus its eventual eop beat
    if (take_sof) begin
      if (free >= FREE_2) begin
        push = 1'b1; wr_sop = 1'b1; len_d = 10'd1; state_d = FRAME;
      end else begin
        inc_drop = 1'b1; state_d = DROP;
      end
    end
  end

  // Saturating statistics
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
      drop_cnt  <= '0;
    end else begin
      if (inc_frame && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
      if (inc_err   && err_cnt   != 16'hFFFF) err_cnt   <= err_cnt   + 16'd1;
      if (inc_drop  && drop_cnt  != 16'hFFFF) drop_cnt  <= drop_cnt  + 16'd1;
    end
  end

endmodule
